easyaxi_rd_resp_gen: RTL
========================

# easyaxi_rd_resp_gen

Slave-side AXI read-response generator: the consumer end of the read-request FIFO. It pops one queued AR request at a time from an `EASYAXI_FIFO` instance, then plays it out as an INCR burst on the AXI R channel with correct RID, RLAST and RRESP. RDATA is an address-derived pattern, which makes the block self-checking for master-side verification.

## Interface
- `ID_WIDTH`, 4, RID/ARID width
- `ADDR_WIDTH`, 16, byte-address width
- `LEN_WIDTH`, 8, ARLEN width (beats = len+1)
- `DATA_WIDTH`, 32, RDATA width; power of two, at least 8
- `MEM_BYTES`, 4096, size of the decoded address window (used only with the configuration macro)
- `clk`  in  1  sole clock; all logic on posedge
- `rst`  in  1  reset, synchronous and active-high
- `req_empty`  in  1  request FIFO empty flag
- `req_data`  in  ID+ADDR+LEN  FIFO head, packed {id, addr, len}, combinationally valid while `req_empty`=0
- `req_rd`  out  1  FIFO pop strobe
- `rvalid`  out  1  R beat valid
- `rready`  in  1  master accepts beat
- `rid`  out  ID_WIDTH  ID of current burst
- `rdata`  out  DATA_WIDTH  beat byte address, zero-extended or truncated to DATA_WIDTH
- `rresp`  out  2  00 OKAY / 10 SLVERR
- `rlast`  out  1  final beat of burst
- `busy`  out  1  burst in progress (state = BURST)

## Operation
- States: IDLE and BURST.
- IDLE:
  - `req_rd` = (state==IDLE) && !`req_empty`; combinational, at most one cycle per request.
  - On that edge, capture id/addr/len, clear `beat_cnt`, go to BURST.
- BURST:
  - `rvalid`=1.
  - On handshake (`rvalid`&&`rready`):
    - If `beat_cnt`==len, go to IDLE.
    - Otherwise `beat_cnt`+=1 and `addr`+=DATA_WIDTH/8, modulo 2^ADDR_WIDTH. Wrap at the top of the address space is silent.
- `rlast` = BURST && (`beat_cnt`==len). For len=0 this gives a single beat with `rlast`=1.
- `rid`, `rdata`, `rresp` and `rlast` are derived from registered state only. They are held stable while `rvalid`&&!`rready`.
- Requests are never reordered, dropped or duplicated, except across reset.
- `beat_cnt` is LEN_WIDTH bits; len = 2^LEN_WIDTH−1 is legal and must not overflow.

## Timing
- Reset values: state IDLE; `rvalid`=0, `rlast`=0, `busy`=0, `rid`=0, `rdata`=0, `rresp`=00.
  - `req_rd`=0 during the reset cycle regardless of `req_empty`.
- Latency:
  - `req_empty` falls in cycle N → `req_rd`=1 in cycle N.
  - First `rvalid` in cycle N+1.
- With `rready` held high, a burst of L+1 beats occupies cycles N+1…N+1+L.
- The earliest next pop is the cycle after the `rlast` handshake, which leaves one idle bubble between bursts. Back-to-back bursts are not required.
- The FIFO may be written while BURST is active; new entries wait.
- `req_rd` is never asserted in BURST. An empty FIFO in IDLE means no activity.
- `rready` is ignored while `rvalid`=0.
- Reset asserted mid-burst:
  - Next cycle is IDLE with `rvalid`=0.
  - The in-flight request is discarded and not re-popped.
  - The FIFO is reset by the same `rst`.

## Configuration
- `EASYAXI_RD_ADDR_CHK_EN` defined:
  - Each beat whose current address ≥ MEM_BYTES returns `rresp`=10 (SLVERR) and `rdata`=0.
  - Beats inside the window return OKAY.
  - The check is per beat, so a burst may cross from OKAY to SLVERR.
  - Burst length and `rlast` are unaffected.
- Undefined: `rresp` is tied to 00, there is no address comparison logic, and `rdata` is always the address pattern.

## Test plan
- Single beat: push {id=3, addr=0x0040, len=0}, `rready`=1 → one pop; one beat with rid=3, rdata=0x00000040, rlast=1, rresp=00; returns to IDLE.
- Burst with backpressure: {id=5, addr=0x0100, len=3}, `rready` toggling 1,0,0,1,… → rdata 0x100, 0x104, 0x108, 0x10C; outputs stable during stalls; rlast only on 0x10C.
- Ordering: push three requests (ids 1, 2, 7; len 1, 0, 2) back to back → exactly three pops; 6 beats in id order 1,1,2,7,7,7; one bubble cycle between bursts.
- Wrap and max length: {addr=0xFFF8, len=255} → beats 0xFFF8, 0xFFFC, 0x0000, …; exactly 256 beats; rlast on beat 256.
- Reset mid-burst: assert `rst` on beat 2 of a len=7 burst → `rvalid`=0 and `busy`=0 the next cycle; no pop until a new push.
- With `EASYAXI_RD_ADDR_CHK_EN`: {addr=0x0FF8, len=3} → resp OKAY, OKAY, SLVERR, SLVERR; rdata 0x0FF8, 0x0FFC, 0, 0.

Source files
------------

// File: rtl/easyaxi_rd_resp_gen.sv
// easyaxi_rd_resp_gen: slave-side AXI read-response generator.
// Pops one queued AR request {id, addr, len} from the request FIFO and plays it
// out as an INCR burst on the R channel.
// RDATA carries the beat byte address, so a master can check every beat.
// Optional feature: define EASYAXI_RD_ADDR_CHK_EN to return SLVERR (with zero
// data) for every beat whose address lies at or beyond MEM_BYTES.
module easyaxi_rd_resp_gen #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_BYTES  = 4096
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      req_empty,
    input  logic [ID_WIDTH+ADDR_WIDTH+LEN_WIDTH-1:0]  req_data,
    output logic                                      req_rd,
    output logic                                      rvalid,
    input  logic                                      rready,
    output logic [ID_WIDTH-1:0]                       rid,
    output logic [DATA_WIDTH-1:0]                     rdata,
    output logic [1:0]                                rresp,
    output logic                                      rlast,
    output logic                                      busy
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(DATA_WIDTH / 8);

    // Elaboration-time sanity check on the configuration.
    if (DATA_WIDTH < 8 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0 || MEM_BYTES < 1) begin : g_bad_cfg
        $error("easyaxi_rd_resp_gen: illegal DATA_WIDTH or MEM_BYTES");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    beat_cnt_q, beat_cnt_d;

    logic [ID_WIDTH-1:0]     head_id;
    logic [ADDR_WIDTH-1:0]   head_addr;
    logic [LEN_WIDTH-1:0]    head_len;
    logic                    last_beat;

    // Split the FIFO head into its {id, addr, len} fields.
    always_comb begin
        head_len  = req_data[LEN_WIDTH-1:0];
        head_addr = req_data[LEN_WIDTH +: ADDR_WIDTH];
        head_id   = req_data[LEN_WIDTH+ADDR_WIDTH +: ID_WIDTH];
    end

    // Next-state logic: pop in IDLE, step address/count on each accepted beat.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        req_rd     = 1'b0;
        last_beat  = (beat_cnt_q == len_q);
        case (state_q)
            IDLE: begin
                // rst gates the pop so nothing leaves the FIFO during reset.
                if (!req_empty && !rst) begin
                    req_rd     = 1'b1;
                    id_d       = head_id;
                    addr_d     = head_addr;
                    len_d      = head_len;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (rready) begin
                    // Counter stops at len, so len = all-ones cannot overflow it.
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                        addr_d     = addr_q + ADDR_INC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // R-channel outputs decoded purely from registered state.
    always_comb begin
        busy   = (state_q == BURST);
        rvalid = busy;
        rid    = id_q;
        rlast  = busy && (beat_cnt_q == len_q);
`ifdef EASYAXI_RD_ADDR_CHK_EN
        if ({1'b0, addr_q} >= (ADDR_WIDTH + 1)'(MEM_BYTES)) begin
            rresp = 2'b10;
            rdata = '0;
        end else begin
            rresp = 2'b00;
            rdata = DATA_WIDTH'(addr_q);
        end
`else
        rresp = 2'b00;
        rdata = DATA_WIDTH'(addr_q);
`endif
    end

endmodule
